// File: rtl/credit_rr_scheduler.sv
// credit_rr_scheduler: round-robin scheduler with a per-grant burst quantum
// that shares one credit-flow-controlled output among four requesters.
// Optional per-channel beat counters are built when the macro
// CREDIT_RR_SCHEDULER_STATS_EN is defined. Otherwise stat_count reads 0.
module credit_rr_scheduler #(
  parameter int DATA_W      = 64,
  parameter int CRED_W      = 8,
  parameter int QUANTUM     = 4,
  parameter int INIT_CREDIT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req_valid,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_grant,
  input  logic [3:0]            chan_en,
  input  logic                  dn_update,
  input  logic [CRED_W-1:0]     dn_credit,
  output logic                  out_valid,
  output logic [1:0]            out_channel,
  output logic [DATA_W-1:0]     out_data,
  output logic [CRED_W-1:0]     credit_count,
  output logic                  credit_ovf,
  output logic                  busy,
  input  logic [1:0]            stat_sel,
  input  logic                  stat_clr,
  output logic [31:0]           stat_count
);

  localparam logic [0:0]        IDLE      = 1'b0;
  localparam logic [0:0]        GRANT     = 1'b1;
  localparam logic [7:0]        QUANT_LIM = 8'(QUANTUM);
  localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(INIT_CREDIT);
  localparam logic [CRED_W:0]   CRED_MAX  = {1'b0, {CRED_W{1'b1}}};

  logic [0:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_owner_q, last_owner_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic              credit_ovf_q, credit_ovf_d;
  logic              out_valid_q;
  logic [1:0]        out_channel_q;
  logic [DATA_W-1:0] out_data_q;

  logic [3:0]        eligible;
  logic              anyElig;
  logic              ownerElig;
  logic              grant;
  logic [7:0]        beatNext;
  logic              exitBurst;
  logic [CRED_W:0]   creditSum;
  logic [CRED_W:0]   creditNet;

  // First eligible channel strictly after 'last', wrapping so 'last' itself comes last
  function automatic logic [1:0] rrPick(input logic [3:0] elig, input logic [1:0] last);
    logic [1:0] res;
    logic [1:0] cand;
    logic       found;
    res   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && elig[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign eligible  = req_valid & chan_en;
  assign anyElig   = |eligible;
  assign ownerElig = eligible[owner_q];
  assign grant     = (state_q == GRANT) && ownerElig && (credit_q != '0);
  assign req_grant = grant ? (4'b0001 << owner_q) : 4'b0000;
  assign beatNext  = beat_cnt_q + 8'd1;
  assign exitBurst = !ownerElig || (grant && (beatNext == QUANT_LIM));

  // Arbitration: start a burst from IDLE, then count beats and hand off on exit
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    if (state_q == IDLE) begin
      if (anyElig) begin
        state_d    = GRANT;
        owner_d    = rrPick(eligible, last_owner_q);
        beat_cnt_d = 8'd0;
      end
    end else begin
      if (grant) begin
        beat_cnt_d = beatNext;
      end
      if (exitBurst) begin
        last_owner_d = owner_q;
        if (anyElig) begin
          owner_d    = rrPick(eligible, owner_q);
          beat_cnt_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // Credit bookkeeping: returns and consumption net out, saturating at the top
  always_comb begin
    creditSum    = {1'b0, credit_q} + (dn_update ? {1'b0, dn_credit} : '0);
    creditNet    = creditSum - (CRED_W+1)'(grant);
    credit_d     = creditNet[CRED_W-1:0];
    credit_ovf_d = credit_ovf_q;
    if (creditNet > CRED_MAX) begin
      credit_d     = CRED_MAX[CRED_W-1:0];
      credit_ovf_d = 1'b1;
    end
  end

  // Control and credit state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      beat_cnt_q   <= 8'd0;
      credit_q     <= CRED_INIT;
      credit_ovf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      credit_q     <= credit_d;
      credit_ovf_q <= credit_ovf_d;
    end
  end

  // Output beat register loads on every grant cycle; valid drops otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_channel_q <= 2'd0;
      out_data_q    <= '0;
    end else if (grant) begin
      out_valid_q   <= 1'b1;
      out_channel_q <= owner_q;
      out_data_q    <= req_data[int'(owner_q)*DATA_W +: DATA_W];
    end else begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_channel  = out_channel_q;
  assign out_data     = out_data_q;
  assign credit_count = credit_q;
  assign credit_ovf   = credit_ovf_q;
  assign busy         = (state_q == GRANT);

`ifdef CREDIT_RR_SCHEDULER_STATS_EN
  logic [31:0] stat_q [4];

  // Per-channel beat counters; a clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= 32'd0;
    end else if (stat_clr) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= 32'd0;
    end else if (grant) begin
      stat_q[owner_q] <= stat_q[owner_q] + 32'd1;
    end
  end

  assign stat_count = stat_q[stat_sel];
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, stat_clr};
  assign stat_count  = 32'd0;
`endif

endmodule

// File: doc/credit_rr_scheduler.md
Name: credit_rr_scheduler

Overview:
Shares one credit-flow-controlled 64-bit output source among 4 requesters. Uses round-robin arbitration with a per-grant burst quantum. Tracks downstream credits and issues one data beat per consumed credit. Sits in front of source_sel, driving its channel/data/valid and absorbing its credit/update returns.

Parameters:
DATA_W, 64, data beat width
CRED_W, 8, downstream credit counter width
QUANTUM, 4, maximum beats per grant before rotation (1..255)
INIT_CREDIT, 0, credit count loaded at reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  4  requester i has a beat on req_data slice i
req_data  in  4*DATA_W  beat data; slice i is [i*DATA_W +: DATA_W]
req_grant  out  4  one-hot; beat i accepted this cycle
chan_en  in  4  per-channel enable mask
dn_update  in  1  pulse: add dn_credit to the counter
dn_credit  in  CRED_W  credits returned with dn_update
out_valid  out  1  registered output beat valid
out_channel  out  2  channel of the output beat
out_data  out  DATA_W  output beat data
credit_count  out  CRED_W  current credit count
credit_ovf  out  1  sticky flag: credit add saturated
busy  out  1  state is GRANT
stat_sel  in  2  STATS_EN only: channel counter select
stat_clr  in  1  STATS_EN only: clear all counters
stat_count  out  32  STATS_EN only: selected beat counter

Behaviour:
- Reset (async assert, sync release) drives the block to these values:
  - state=IDLE, owner=0, last_owner=3 (channel 0 wins first), beat_cnt=0.
  - credit=INIT_CREDIT, credit_ovf=0.
  - req_grant, out_valid, out_channel, out_data all 0.
  - Reset mid-burst drops the burst immediately. No partial beat is emitted.
- eligible[i] = req_valid[i] & chan_en[i].
- Round-robin pick searches from last_owner+1 upward, modulo 4. The current owner is therefore last priority.
- States:
  - IDLE: if any eligible, owner<=pick, beat_cnt<=0, go to GRANT. req_grant stays 0 in IDLE.
  - GRANT: req_grant[owner]=1 combinationally iff eligible[owner] and credit!=0.
    - On a grant: beat_cnt++, credit decrements, data is captured.
    - Exit condition is any one of:
      - !eligible[owner];
      - the granted beat makes beat_cnt reach QUANTUM.
    - On exit, last_owner<=owner. If any eligible (re-evaluated with the new last_owner), owner<=pick and stay in GRANT (bubble-free handoff). Otherwise go to IDLE.
    - If credit==0 and eligible[owner], stay in GRANT with no grant (stall). beat_cnt does not change.
- Latency:
  - req_valid rising in IDLE gives a grant 1 cycle later and out_valid 2 cycles later.
  - Output registers load on the grant cycle: out_valid=1, out_channel=owner, out_data=slice.
  - out_valid=0 on any cycle after a cycle with no grant.
- Credit arithmetic: next = credit + (dn_update ? dn_credit : 0) − (grant ? 1 : 0).
  - Simultaneous add and consume nets out.
  - A result above 2^CRED_W−1 saturates at the maximum and sets credit_ovf. credit_ovf is cleared only by reset.
  - A credit returned in cycle N is usable for a grant in cycle N+1, not cycle N.
- chan_en cleared for the owner ends the burst at once, using the exit rules above.
- busy = (state==GRANT).

Optional Feature:
- Macro: CREDIT_RR_SCHEDULER_STATS_EN.
- When defined:
  - Four 32-bit wrapping counters, each incremented on every req_grant[i].
  - stat_count = counter[stat_sel], combinational.
  - stat_clr zeroes all counters the next cycle. A clear takes priority over a same-cycle increment.
- When undefined: counters are absent, stat_count is tied to 0, and stat_sel/stat_clr are ignored.

Test Plan:
- INIT_CREDIT=0; req_valid=4'b0001 held; one dn_update with dn_credit=3 -> exactly 3 grants to channel 0. out_valid on 3 beats with out_channel=0. Then stall in GRANT with credit_count=0 and busy=1.
- Credit=100; all four channels requesting continuously; QUANTUM=4 -> out_channel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0… with no idle cycle between bursts.
- Credit=100; only channel 2 requests, for 2 cycles -> grants in cycles 1 and 2, out_valid in cycles 2 and 3, then IDLE. Channel 1 then requests -> granted after one IDLE cycle.
- Credit=250; dn_update with dn_credit=10 while no grant -> credit_count=255 and credit_ovf=1 (sticky). A grant in the same cycle as an update of 1 at credit=5 -> credit stays 5.
- Mid-burst chan_en[owner]=0 -> grant drops that cycle and the next eligible channel is granted the following cycle. Reset asserted mid-burst -> all outputs 0 immediately, and credit_count=INIT_CREDIT.
- STATS_EN: 6 grants to channel 3, then stat_sel=3 -> stat_count=6. stat_clr -> 0 the next cycle.
